// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave bundle for one port of onchip_memory_dp.
// The master drives address, control and write data; the memory returns read data and handshake.
interface onchip_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0]   address;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves, pipelined read returns
// and an optional post-reset zero-fill sequencer that holds both masters off.
module onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 15,
    parameter int DEPTH          = 30000,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clken,
    onchip_memory_dp_if.slave s1,
    onchip_memory_dp_if.slave s2
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_V   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic                    w_wait;
    logic                    w_clr_we;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_acc [2];
    logic                    w_wr  [2];
    logic                    w_rd  [2];
    logic                    w_inr [2];
    logic [IDX_W-1:0]        w_idx [2];

    logic [READ_LATENCY-1:0] r_vld [2];
    logic [DATA_WIDTH-1:0]   r_dat [2][READ_LATENCY];

    // Port decode: read and write together is treated as a write only.
    assign w_acc[0] = s1.chipselect & (s1.read | s1.write) & ~w_wait;
    assign w_acc[1] = s2.chipselect & (s2.read | s2.write) & ~w_wait;
    assign w_wr[0]  = w_acc[0] & s1.write;
    assign w_wr[1]  = w_acc[1] & s2.write;
    assign w_rd[0]  = w_acc[0] & ~s1.write;
    assign w_rd[1]  = w_acc[1] & ~s2.write;
    assign w_inr[0] = {1'b0, s1.address} < DEPTH_V;
    assign w_inr[1] = {1'b0, s2.address} < DEPTH_V;
    assign w_idx[0] = s1.address[IDX_W-1:0];
    assign w_idx[1] = s2.address[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_clr_addr <= '0;
        end else if (clken) begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RESET: w_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            ST_CLEAR: if (r_clr_addr == LAST_ADDR) w_next = ST_READY;
            ST_READY: w_next = ST_READY;
            default:  w_next = ST_RESET;
        endcase
    end

    always_comb begin
        w_wait   = 1'b1;
        w_clr_we = 1'b0;
        if (!reset && clken) begin
            w_wait   = (r_state != ST_READY);
            w_clr_we = (r_state == ST_CLEAR);
        end
    end

    // NOTE: the array has no reset branch; only the clear sequencer zeroes it, so it stays a plain RAM.
    // s2 lanes are assigned first so any lane s1 also enables is overwritten by s1.
    always_ff @(posedge clk) begin
        if (w_clr_we) r_mem[r_clr_addr[IDX_W-1:0]] <= '0;
        for (int b = 0; b < NB; b++) begin
            if (w_wr[1] && w_inr[1] && s2.byteenable[b])
                r_mem[w_idx[1]][8*b +: 8] <= s2.writedata[8*b +: 8];
            if (w_wr[0] && w_inr[0] && s1.byteenable[b])
                r_mem[w_idx[0]][8*b +: 8] <= s1.writedata[8*b +: 8];
        end
    end

    // Read pipeline samples the array before this edge's writes land (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p] <= '0;
                for (int i = 0; i < READ_LATENCY; i++) r_dat[p][i] <= '0;
            end
        end else if (clken) begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p][0] <= w_rd[p];
                r_dat[p][0] <= w_inr[p] ? r_mem[w_idx[p]] : '0;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    r_vld[p][i] <= r_vld[p][i-1];
                    r_dat[p][i] <= r_dat[p][i-1];
                end
            end
        end
    end

    // A valid held during a clken stall is shown only once, on the first enabled cycle.
    assign s1.readdata      = r_dat[0][READ_LATENCY-1];
    assign s2.readdata      = r_dat[1][READ_LATENCY-1];
    assign s1.readdatavalid = r_vld[0][READ_LATENCY-1] & clken & ~reset;
    assign s2.readdatavalid = r_vld[1][READ_LATENCY-1] & clken & ~reset;
    assign s1.waitrequest   = w_wait;
    assign s2.waitrequest   = w_wait;
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (read latency 1 and 2) share one stimulus,
// a reference memory feeds per-port expected-read queues, plus directed timing checks.
module tb_onchip_memory_dp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clken = 1'b1;
    always #5 clk = ~clk;

    logic          m_cs   [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [AW-1:0] m_addr [2];
    logic [3:0]    m_be   [2];
    logic [DW-1:0] m_wd   [2];

    // Output index k: 0 = A.s1, 1 = A.s2 (latency 1), 2 = B.s1, 3 = B.s2 (latency 2).
    logic          o_wait [4];
    logic          o_vld  [4];
    logic [DW-1:0] o_data [4];

    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a2 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();
    onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b2 ();

    assign a1.address = m_addr[0]; assign a1.chipselect = m_cs[0]; assign a1.read = m_rd[0];
    assign a1.write = m_wr[0]; assign a1.byteenable = m_be[0]; assign a1.writedata = m_wd[0];
    assign a2.address = m_addr[1]; assign a2.chipselect = m_cs[1]; assign a2.read = m_rd[1];
    assign a2.write = m_wr[1]; assign a2.byteenable = m_be[1]; assign a2.writedata = m_wd[1];
    assign b1.address = m_addr[0]; assign b1.chipselect = m_cs[0]; assign b1.read = m_rd[0];
    assign b1.write = m_wr[0]; assign b1.byteenable = m_be[0]; assign b1.writedata = m_wd[0];
    assign b2.address = m_addr[1]; assign b2.chipselect = m_cs[1]; assign b2.read = m_rd[1];
    assign b2.write = m_wr[1]; assign b2.byteenable = m_be[1]; assign b2.writedata = m_wd[1];

    assign o_wait[0] = a1.waitrequest; assign o_vld[0] = a1.readdatavalid; assign o_data[0] = a1.readdata;
    assign o_wait[1] = a2.waitrequest; assign o_vld[1] = a2.readdatavalid; assign o_data[1] = a2.readdata;
    assign o_wait[2] = b1.waitrequest; assign o_vld[2] = b1.readdatavalid; assign o_data[2] = b1.readdata;
    assign o_wait[3] = b2.waitrequest; assign o_vld[3] = b2.readdatavalid; assign o_data[3] = b2.readdata;

    onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .s1(a1), .s2(a2));
    onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                       .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .s1(b1), .s2(b2));

    int            checks   = 0;
    int            failures = 0;
    int            pops [4];
    logic [DW-1:0] sb [4][$];
    logic [DW-1:0] model [DEPTH];

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? model[a[3:0]] : '0;
    endfunction

    task automatic idle_port(input int p);
        m_cs[p] = 1'b0; m_rd[p] = 1'b0; m_wr[p] = 1'b0;
        m_addr[p] = '0; m_be[p] = '0; m_wd[p] = '0;
    endtask

    task automatic idle();
        idle_port(0);
        idle_port(1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        m_cs[p] = 1'b1; m_wr[p] = 1'b1; m_rd[p] = 1'b0;
        m_addr[p] = a; m_wd[p] = d; m_be[p] = be;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        m_cs[p] = 1'b1; m_wr[p] = 1'b0; m_rd[p] = 1'b1;
        m_addr[p] = a; m_be[p] = 4'hF; m_wd[p] = '0;
    endtask

    task automatic drain();
        idle();
        repeat (5) cyc();
    endtask

    // Pops on every read return, pushes on every accepted read, then applies accepted writes.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                automatic int p = k % 2;
                automatic logic [DW-1:0] exp_d;
                if (o_vld[k]) begin
                    checks++;
                    if (sb[k].size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected_valid k=%0d got=%h required=no_return", k, o_data[k]);
                    end else begin
                        exp_d = sb[k].pop_front();
                        pops[k]++;
                        if (o_data[k] !== exp_d) begin
                            failures++;
                            $display("FAIL sb_readdata k=%0d got=%h required=%h", k, o_data[k], exp_d);
                        end
                    end
                end
                if (m_cs[p] && m_rd[p] && !m_wr[p] && !o_wait[k])
                    sb[k].push_back(model_rd(m_addr[p]));
            end
            for (int p = 1; p >= 0; p--) begin
                if (m_cs[p] && m_wr[p] && !o_wait[p] && int'(m_addr[p]) < DEPTH)
                    for (int b = 0; b < 4; b++)
                        if (m_be[p][b]) model[m_addr[p][3:0]][8*b +: 8] = m_wd[p][8*b +: 8];
            end
        end
    endtask

    // Holds reset two edges, releases it and counts cycles with waitrequest high.
    task automatic reset_and_clear(output int n);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!o_wait[0]) break;
            n++;
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        cyc();
    endtask

    task automatic fill_ones();
        for (int i = 0; i < DEPTH; i++) begin
            wr(0, AW'(i), '1, 4'hF);
            cyc();
        end
        idle();
        cyc();
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd(0, AW'(i));
            rd(1, AW'(DEPTH - 1 - i));
            cyc();
        end
        drain();
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_wait[k] !== 1'b1) begin failures++; $display("FAIL reset_wait k=%0d got=%b required=1", k, o_wait[k]); end
            checks++;
            if (o_vld[k] !== 1'b0) begin failures++; $display("FAIL reset_valid k=%0d got=%b required=0", k, o_vld[k]); end
            checks++;
            if (o_data[k] !== '0) begin failures++; $display("FAIL reset_data k=%0d got=%h required=0", k, o_data[k]); end
        end
        reset_and_clear(n);
        checks++;
        if (n !== DEPTH + 1) begin failures++; $display("FAIL first_clear_cycles got=%0d required=%0d", n, DEPTH + 1); end
    endtask

    task automatic test_clear();
        int n;
        fill_ones();
        reset_and_clear(n);
        checks++;
        if (n !== DEPTH + 1) begin failures++; $display("FAIL clear_cycles got=%0d required=%0d", n, DEPTH + 1); end
        read_all();
    endtask

    task automatic test_byte_lanes();
        wr(0, 5'd5, 32'h11223344, 4'hF); cyc();
        wr(0, 5'd5, 32'hAABBCCDD, 4'b0101); cyc();
        idle(); wr(1, 5'd5, 32'hFFFFFFFF, 4'b0000); cyc();
        idle(); rd(0, 5'd5);
        @(posedge clk); #1; idle();
        @(negedge clk);
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[0] !== 32'h11BB33DD) begin
            failures++; $display("FAIL bytelane_rl1 got=%b/%h required=1/11bb33dd", o_vld[0], o_data[0]);
        end
        checks++;
        if (o_vld[2] !== 1'b0) begin failures++; $display("FAIL bytelane_rl2_early got=%b required=0", o_vld[2]); end
        @(negedge clk);
        checks++;
        if (o_vld[2] !== 1'b1 || o_data[2] !== 32'h11BB33DD) begin
            failures++; $display("FAIL bytelane_rl2 got=%b/%h required=1/11bb33dd", o_vld[2], o_data[2]);
        end
        checks++;
        if (o_vld[0] !== 1'b0) begin failures++; $display("FAIL bytelane_rl1_dup got=%b required=0", o_vld[0]); end
        drain();
    endtask

    task automatic test_collision();
        wr(0, 5'd7, 32'h12345678, 4'b0011);
        wr(1, 5'd7, 32'h9ABCDEF0, 4'b1111);
        cyc();
        idle(); rd(0, 5'd7);
        @(posedge clk); #1; idle();
        @(negedge clk);
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[0] !== 32'h9ABC5678) begin
            failures++; $display("FAIL dual_write got=%b/%h required=1/9abc5678", o_vld[0], o_data[0]);
        end
        drain();
    endtask

    task automatic test_read_during_write();
        wr(0, 5'd3, 32'hCAFEF00D, 4'hF);
        rd(1, 5'd3);
        @(posedge clk); #1; idle_port(0);
        @(negedge clk);
        checks++;
        if (o_vld[1] !== 1'b1 || o_data[1] !== 32'h0) begin
            failures++; $display("FAIL rdw_old got=%b/%h required=1/00000000", o_vld[1], o_data[1]);
        end
        @(posedge clk); #1; idle();
        @(negedge clk);
        checks++;
        if (o_vld[1] !== 1'b1 || o_data[1] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL rdw_new got=%b/%h required=1/cafef00d", o_vld[1], o_data[1]);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            wr(0, AW'(i), $urandom, 4'hF);
            wr(1, AW'(8 + i), $urandom, 4'(i + 1));
            cyc();
        end
        read_all();
    endtask

    task automatic test_clken_stall();
        int idx = 0;
        int base0, base2;
        for (int i = 0; i < 4; i++) begin
            wr(0, AW'(8 + i), 32'hC0DE0000 + 32'(i), 4'hF);
            cyc();
        end
        idle(); cyc();
        base0 = pops[0];
        base2 = pops[2];
        for (int c = 0; c < 12; c++) begin
            clken = !(c >= 2 && c <= 4);
            if (idx < 4) rd(0, AW'(8 + idx));
            else idle();
            @(negedge clk);
            if (!clken) begin
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (o_wait[k] !== 1'b1) begin failures++; $display("FAIL stall_wait k=%0d c=%0d got=%b required=1", k, c, o_wait[k]); end
                end
            end
            @(posedge clk);
            if (clken && idx < 4) idx++;
            #1;
        end
        clken = 1'b1;
        drain();
        checks++;
        if (pops[0] - base0 !== 4) begin failures++; $display("FAIL stall_pulses_rl1 got=%0d required=4", pops[0] - base0); end
        checks++;
        if (pops[2] - base2 !== 4) begin failures++; $display("FAIL stall_pulses_rl2 got=%0d required=4", pops[2] - base2); end
    endtask

    task automatic test_midclear_out_of_range();
        int n;
        fill_ones();
        reset = 1'b1; cyc(); cyc();
        reset = 1'b0;
        repeat (9) cyc();
        reset_and_clear(n);
        checks++;
        if (n !== DEPTH + 1) begin failures++; $display("FAIL midclear_restart got=%0d required=%0d", n, DEPTH + 1); end
        read_all();
        wr(0, 5'd0, 32'h5A5A5A5A, 4'hF); cyc();
        idle(); rd(0, 5'd16); rd(1, 5'd31);
        @(posedge clk); #1; idle();
        @(negedge clk);
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[0] !== 32'h0) begin
            failures++; $display("FAIL oor_read got=%b/%h required=1/00000000", o_vld[0], o_data[0]);
        end
        cyc();
        wr(0, 5'd16, 32'hDEADBEEF, 4'hF); cyc();
        idle(); rd(0, 5'd0);
        @(posedge clk); #1; idle();
        @(negedge clk);
        checks++;
        if (o_vld[0] !== 1'b1 || o_data[0] !== 32'h5A5A5A5A) begin
            failures++; $display("FAIL oor_write got=%b/%h required=1/5a5a5a5a", o_vld[0], o_data[0]);
        end
        drain();
    endtask

    initial begin
        idle();
        for (int k = 0; k < 4; k++) pops[k] = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_clear();
        test_byte_lanes();
        test_collision();
        test_read_during_write();
        test_back_to_back();
        test_clken_stall();
        test_midclear_out_of_range();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (sb[k].size() !== 0) begin
                failures++; $display("FAIL sb_missing_returns k=%0d got=%0d required=0", k, sb[k].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
